// File: rtl/sdram_ctrl_fsm_if.sv
// System-side handshake and state bundle between the SDRAM control FSM and its users.
interface sdram_ctrl_fsm_if;
    logic        sys_wr_req;
    logic        sys_rd_req;
    logic [8:0]  sdwr_bytes;
    logic [8:0]  sdrd_bytes;
    logic [3:0]  init_state;
    logic [3:0]  work_state;
    logic [15:0] cnt_clk;
    logic        sys_r_wn;
    logic        sdram_busy;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic        init_done;

    modport master (
        output sys_wr_req, sys_rd_req, sdwr_bytes, sdrd_bytes,
        input  init_state, work_state, cnt_clk, sys_r_wn,
               sdram_busy, sdram_wr_ack, sdram_rd_ack, init_done
    );

    modport slave (
        input  sys_wr_req, sys_rd_req, sdwr_bytes, sdrd_bytes,
        output init_state, work_state, cnt_clk, sys_r_wn,
               sdram_busy, sdram_wr_ack, sdram_rd_ack, init_done
    );
endinterface

// File: rtl/sdram_ctrl_fsm.sv
// SDRAM control FSM: power-up init, then fixed-priority refresh/write/read arbitration
// with registered state, dwell counter and system-side strobes.
module sdram_ctrl_fsm #(
    parameter int T_POWERUP = 20000,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 7,
    parameter int T_MRD     = 2,
    parameter int T_RCD     = 3,
    parameter int CL        = 3,
    parameter int T_DAL     = 5,
    parameter int T_REF     = 780
) (
    input  logic               clk_100m,
    input  logic               rst,
    sdram_ctrl_fsm_if.slave    bus
);
    typedef enum logic [3:0] {
        I_NOP = 4'd0, I_PRECHARGE = 4'd1, I_TRP = 4'd2, I_AUTO_REFRESH1 = 4'd3,
        I_TRF1 = 4'd4, I_AUTO_REFRESH2 = 4'd5, I_TRF2 = 4'd6, I_MRS = 4'd7,
        I_TMRD = 4'd8, I_DONE = 4'd9
    } init_t;

    typedef enum logic [3:0] {
        W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3, W_CL = 4'd4,
        W_RD = 4'd5, W_WRITE = 4'd6, W_WD = 4'd7, W_TDAL = 4'd8, W_AR = 4'd9,
        W_TRFC = 4'd10
    } work_t;

    init_t       init_q, init_d;
    work_t       work_q, work_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] ref_q, ref_d;
    logic [9:0]  len_q, len_d;
    logic        rwn_q, rwn_d;
    logic        pend_q, pend_d;
    logic        wack_q, rack_q, busy_q, done_q;

    function automatic logic [9:0] burst_len(input logic [8:0] b);
        return (b == 9'd0) ? 10'd512 : {1'b0, b};
    endfunction

    function automatic logic dwell_done(input logic [15:0] cnt, input int t);
        return cnt == 16'(t - 1);
    endfunction

    always_comb begin
        init_d = init_q;
        work_d = work_q;
        len_d  = len_q;
        rwn_d  = rwn_q;
        ref_d  = ref_q;
        pend_d = pend_q;

        case (init_q)
            I_NOP:           if (dwell_done(cnt_q, T_POWERUP)) init_d = I_PRECHARGE;
            I_PRECHARGE:     init_d = I_TRP;
            I_TRP:           if (dwell_done(cnt_q, T_RP)) init_d = I_AUTO_REFRESH1;
            I_AUTO_REFRESH1: init_d = I_TRF1;
            I_TRF1:          if (dwell_done(cnt_q, T_RFC)) init_d = I_AUTO_REFRESH2;
            I_AUTO_REFRESH2: init_d = I_TRF2;
            I_TRF2:          if (dwell_done(cnt_q, T_RFC)) init_d = I_MRS;
            I_MRS:           init_d = I_TMRD;
            I_TMRD:          if (dwell_done(cnt_q, T_MRD)) init_d = I_DONE;
            default:         init_d = I_DONE;
        endcase

        if (init_q != I_DONE) begin
            work_d = W_IDLE;
        end else begin
            case (work_q)
                W_IDLE: begin
                    if (pend_q) begin
                        work_d = W_AR;
                    end else if (bus.sys_wr_req) begin
                        work_d = W_ACTIVE;
                        len_d  = burst_len(bus.sdwr_bytes);
                        rwn_d  = 1'b1;
                    end else if (bus.sys_rd_req) begin
                        work_d = W_ACTIVE;
                        len_d  = burst_len(bus.sdrd_bytes);
                        rwn_d  = 1'b0;
                    end
                end
                W_ACTIVE: work_d = W_TRCD;
                W_TRCD:   if (dwell_done(cnt_q, T_RCD)) work_d = rwn_q ? W_WRITE : W_READ;
                // The WRITE cycle itself carries the first word, so WD covers N-1.
                W_WRITE:  work_d = (len_q == 10'd1) ? W_TDAL : W_WD;
                W_WD:     if (cnt_q == {6'd0, len_q} - 16'd2) work_d = W_TDAL;
                W_READ:   work_d = W_CL;
                W_CL:     if (dwell_done(cnt_q, CL)) work_d = W_RD;
                W_RD:     if (cnt_q == {6'd0, len_q} - 16'd1) work_d = W_TDAL;
                W_TDAL:   if (dwell_done(cnt_q, rwn_q ? T_DAL : T_RP)) work_d = W_IDLE;
                W_AR:     work_d = W_TRFC;
                W_TRFC:   if (dwell_done(cnt_q, T_RFC)) work_d = W_IDLE;
                default:  work_d = W_IDLE;
            endcase
        end

        if (init_d != init_q || work_d != work_q)
            cnt_d = 16'd0;
        else
            cnt_d = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;

        // A tick landing on the same cycle as W_AR entry re-arms pending.
        if (work_d == W_AR && work_q != W_AR) pend_d = 1'b0;
        if (init_q == I_DONE) begin
            if (ref_q == 16'(T_REF - 1)) begin
                ref_d  = 16'd0;
                pend_d = 1'b1;
            end else begin
                ref_d = ref_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            init_q <= I_NOP;
            work_q <= W_IDLE;
            cnt_q  <= 16'd0;
            ref_q  <= 16'd0;
            rwn_q  <= 1'b1;
            pend_q <= 1'b0;
            wack_q <= 1'b0;
            rack_q <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            init_q <= init_d;
            work_q <= work_d;
            cnt_q  <= cnt_d;
            ref_q  <= ref_d;
            rwn_q  <= rwn_d;
            pend_q <= pend_d;
            wack_q <= (work_d == W_WRITE) || (work_d == W_WD);
            rack_q <= (work_d == W_RD);
            busy_q <= !((init_d == I_DONE) && (work_d == W_IDLE));
            done_q <= (init_d == I_DONE);
        end
    end

    always_ff @(posedge clk_100m) begin
        len_q <= len_d;
    end

    assign bus.init_state   = init_q;
    assign bus.work_state   = work_q;
    assign bus.cnt_clk      = cnt_q;
    assign bus.sys_r_wn     = rwn_q;
    assign bus.sdram_busy   = busy_q;
    assign bus.sdram_wr_ack = wack_q;
    assign bus.sdram_rd_ack = rack_q;
    assign bus.init_done    = done_q;
endmodule

// File: tb/tb_sdram_ctrl_fsm.sv
// Bench for sdram_ctrl_fsm: directed transaction table, corner sequences and a
// randomized run against a schedule-queue reference model.
module tb_sdram_ctrl_fsm;
    localparam int T_PU  = 10;
    localparam int T_REF = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_ctrl_fsm_if bus();

    sdram_ctrl_fsm #(.T_POWERUP(T_PU), .T_REF(T_REF)) dut (
        .clk_100m(clk),
        .rst     (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Init dwell lengths for T_POWERUP=10 and default timing.
    function automatic int init_at(input int c);
        int dw[9] = '{T_PU, 1, 3, 1, 7, 1, 7, 1, 2};
        int acc = 0;
        for (int s = 0; s < 9; s++) begin
            acc += dw[s];
            if (c < acc) return s;
        end
        return 9;
    endfunction

    function automatic int blen(input logic [8:0] b);
        return (b == 9'd0) ? 512 : int'(b);
    endfunction

    // Reference model: each accepted transaction is expanded into a queue of
    // per-cycle {state, wr_ack, rd_ack} entries drained one per clock.
    typedef struct packed {logic [3:0] ws; logic wa; logic ra;} seg_t;
    seg_t sched[$];
    bit   m_valid = 0;
    int   m_k, m_cnt, m_age;
    logic [3:0] m_init, m_work;
    logic m_rwn, m_pend, m_wack, m_rack;

    task automatic push_n(input logic [3:0] ws, input int n, input logic wa, input logic ra);
        seg_t s;
        s.ws = ws; s.wa = wa; s.ra = ra;
        for (int i = 0; i < n; i++) sched.push_back(s);
    endtask

    task automatic model_step();
        int n_k, nlen;
        logic [3:0] n_init, n_work;
        logic n_wa, n_ra, tick;
        seg_t s;
        n_k = (m_k < 1000000) ? m_k + 1 : m_k;
        n_init = 4'(init_at(n_k));
        if (m_init == 4'd9 && m_work == 4'd0 && sched.size() == 0) begin
            if (m_pend) begin
                push_n(4'd9, 1, 0, 0); push_n(4'd10, 7, 0, 0);
            end else if (bus.sys_wr_req) begin
                nlen = blen(bus.sdwr_bytes);
                push_n(4'd1, 1, 0, 0); push_n(4'd2, 3, 0, 0); push_n(4'd6, 1, 1, 0);
                push_n(4'd7, nlen - 1, 1, 0); push_n(4'd8, 5, 0, 0);
                m_rwn = 1'b1;
            end else if (bus.sys_rd_req) begin
                nlen = blen(bus.sdrd_bytes);
                push_n(4'd1, 1, 0, 0); push_n(4'd2, 3, 0, 0); push_n(4'd3, 1, 0, 0);
                push_n(4'd4, 3, 0, 0); push_n(4'd5, nlen, 0, 1); push_n(4'd8, 3, 0, 0);
                m_rwn = 1'b0;
            end
        end
        if (sched.size() > 0) begin
            s = sched.pop_front();
            n_work = s.ws; n_wa = s.wa; n_ra = s.ra;
        end else begin
            n_work = 4'd0; n_wa = 1'b0; n_ra = 1'b0;
        end
        if (n_init != m_init || n_work != m_work) m_cnt = 0;
        else if (m_cnt < 65535) m_cnt++;
        tick = 1'b0;
        if (n_init == 4'd9) begin
            m_age = (m_age < 0) ? 0 : m_age + 1;
            tick = (m_age > 0) && (m_age % T_REF == 0);
        end
        if (tick) m_pend = 1'b1;
        else if (n_work == 4'd9 && m_work != 4'd9) m_pend = 1'b0;
        m_k = n_k; m_init = n_init; m_work = n_work; m_wack = n_wa; m_rack = n_ra;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                sched.delete();
                m_k = 0; m_init = 4'd0; m_work = 4'd0; m_cnt = 0; m_age = -1;
                m_rwn = 1'b1; m_pend = 1'b0; m_wack = 1'b0; m_rack = 1'b0;
                m_valid = 1;
            end else if (m_valid) begin
                model_step();
            end
            #1;
            if (m_valid) begin
                chk("m_init_state", bus.init_state, m_init);
                chk("m_work_state", bus.work_state, m_work);
                chk("m_cnt_clk", bus.cnt_clk, m_cnt);
                chk("m_sys_r_wn", bus.sys_r_wn, m_rwn);
                chk("m_busy", bus.sdram_busy, !(m_init == 4'd9 && m_work == 4'd0));
                chk("m_wr_ack", bus.sdram_wr_ack, m_wack);
                chk("m_rd_ack", bus.sdram_rd_ack, m_rack);
                chk("m_init_done", bus.init_done, m_init == 4'd9);
            end
        end
    end

    typedef struct {bit wr; int bytes; bit rwn; int acks; int first; int dur;} vec_t;
    vec_t vt[7];

    task automatic wait_ws(input logic [3:0] ws, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (bus.work_state == ws) return;
            @(negedge clk);
        end
        chk({name, "_timeout"}, bus.work_state, ws);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int j, first, acks, other;
        bus.sys_wr_req = v.wr; bus.sys_rd_req = !v.wr;
        bus.sdwr_bytes = 9'(v.bytes); bus.sdrd_bytes = 9'(v.bytes);
        @(negedge clk);
        wait_ws(4'd1, 2000, "txn_active");
        bus.sys_wr_req = 1'b0; bus.sys_rd_req = 1'b0;
        chk($sformatf("txn%0d_rwn", idx), bus.sys_r_wn, v.rwn);
        j = 0; first = -1; acks = 0; other = 0;
        while (bus.work_state != 4'd0 && j < 1000) begin
            if (v.wr ? bus.sdram_wr_ack : bus.sdram_rd_ack) begin
                if (first < 0) first = j;
                acks++;
            end
            if (v.wr ? bus.sdram_rd_ack : bus.sdram_wr_ack) other++;
            j++;
            @(negedge clk);
        end
        chk($sformatf("txn%0d_acks", idx), acks, v.acks);
        chk($sformatf("txn%0d_first_ack", idx), first, v.first);
        chk($sformatf("txn%0d_duration", idx), j, v.dur);
        chk($sformatf("txn%0d_wrong_ack", idx), other, 0);
    endtask

    initial begin
        int g, last_ar, n_ar, cyc;
        bit saw_ar;
        logic [3:0] prev_ws;

        // {wr, bytes, sys_r_wn, acks, first ack after ACTIVE, cycles ACTIVE..TDAL}
        vt[0] = '{1, 4,  1, 4,   4, 13};
        vt[1] = '{0, 4,  0, 4,   8, 15};
        vt[2] = '{1, 1,  1, 1,   4, 10};
        vt[3] = '{0, 1,  0, 1,   8, 12};
        vt[4] = '{1, 9,  1, 9,   4, 18};
        vt[5] = '{0, 16, 0, 16,  8, 27};
        vt[6] = '{1, 0,  1, 512, 4, 521};

        bus.sys_wr_req = 1'b0; bus.sys_rd_req = 1'b0;
        bus.sdwr_bytes = 9'd0; bus.sdrd_bytes = 9'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_init_state", bus.init_state, 0);
        chk("reset_busy", bus.sdram_busy, 1);
        chk("reset_r_wn", bus.sys_r_wn, 1);
        rst = 1'b0;

        for (int c = 0; c < 35; c++) begin
            chk($sformatf("init_seq_c%0d", c), bus.init_state, init_at(c));
            if (c == 32 || c == 33) begin
                chk($sformatf("init_done_c%0d", c), bus.init_done, c == 33);
                chk($sformatf("busy_c%0d", c), bus.sdram_busy, c != 33);
            end
            @(negedge clk);
        end

        for (int i = 0; i < 7; i++) run_txn(vt[i], i);

        // Simultaneous requests: write first, read on the next idle cycle.
        wait_ws(4'd0, 100, "sim_idle");
        bus.sys_wr_req = 1'b1; bus.sys_rd_req = 1'b1;
        bus.sdwr_bytes = 9'd3; bus.sdrd_bytes = 9'd5;
        @(negedge clk);
        wait_ws(4'd1, 200, "sim_wr_active");
        chk("sim_first_is_write", bus.sys_r_wn, 1);
        bus.sys_wr_req = 1'b0;
        @(negedge clk);
        wait_ws(4'd0, 200, "sim_wr_done");
        g = 0; saw_ar = 0;
        while (bus.work_state != 4'd1 && g < 100) begin
            if (bus.work_state == 4'd9) saw_ar = 1;
            g++;
            @(negedge clk);
        end
        chk("sim_second_is_read", bus.sys_r_wn, 0);
        if (!saw_ar) chk("sim_idle_gap", g, 1);
        bus.sys_rd_req = 1'b0;
        @(negedge clk);
        wait_ws(4'd0, 200, "sim_rd_done");

        // Reset pulsed in the middle of a write burst.
        bus.sys_wr_req = 1'b1; bus.sdwr_bytes = 9'd8;
        @(negedge clk);
        wait_ws(4'd7, 300, "rst_wd");
        bus.sys_wr_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_init_state", bus.init_state, 0);
        chk("rst_mid_work_state", bus.work_state, 0);
        chk("rst_mid_cnt_clk", bus.cnt_clk, 0);
        chk("rst_mid_wr_ack", bus.sdram_wr_ack, 0);
        chk("rst_mid_rd_ack", bus.sdram_rd_ack, 0);
        chk("rst_mid_busy", bus.sdram_busy, 1);
        chk("rst_mid_init_done", bus.init_done, 0);
        rst = 1'b0;
        g = 0;
        while (!bus.init_done && g < 100) begin g++; @(negedge clk); end
        chk("reinit_cycles", g, 33);

        // Continuous requests: refresh must still be taken every interval.
        bus.sys_wr_req = 1'b1; bus.sys_rd_req = 1'b1;
        last_ar = -1; n_ar = 0; prev_ws = bus.work_state;
        for (cyc = 0; cyc < 600; cyc++) begin
            bus.sdwr_bytes = 9'($urandom_range(1, 8));
            bus.sdrd_bytes = 9'($urandom_range(1, 8));
            @(negedge clk);
            if (bus.work_state == 4'd9 && prev_ws != 4'd9) begin
                if (last_ar >= 0) chk_range("ref_interval", cyc - last_ar, T_REF - 20, T_REF + 20);
                last_ar = cyc;
                n_ar++;
            end
            prev_ws = bus.work_state;
        end
        chk_range("ref_count", n_ar, 10, 13);
        bus.sys_wr_req = 1'b0; bus.sys_rd_req = 1'b0;

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.sys_wr_req = ($urandom_range(0, 3) == 0);
            bus.sys_rd_req = ($urandom_range(0, 3) == 0);
            bus.sdwr_bytes = ($urandom_range(0, 99) == 0) ? 9'd0 : 9'($urandom_range(1, 24));
            bus.sdrd_bytes = ($urandom_range(0, 99) == 0) ? 9'd0 : 9'($urandom_range(1, 24));
            @(negedge clk);
        end
        bus.sys_wr_req = 1'b0; bus.sys_rd_req = 1'b0;
        repeat (600) @(negedge clk);
        chk("final_idle", bus.work_state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_ctrl_fsm.md
# sdram_ctrl_fsm

Control state machine for the SDRAM controller. Runs the power-up initialisation sequence, arbitrates system write, read and auto-refresh requests, and publishes `init_state`, `work_state`, `cnt_clk` and `sys_r_wn`. The command-encoding stage turns these into SDRAM pin commands one cycle later. It also gives the system side busy, write-data and read-data strobes aligned to SDRAM pin timing.

## Interface
- `T_POWERUP`, 20000: cycles of NOP after reset (200 us at 100 MHz).
- `T_RP`, 3: precharge wait, cycles.
- `T_RFC`, 7: auto-refresh wait, cycles.
- `T_MRD`, 2: mode-register-set wait, cycles.
- `T_RCD`, 3: ACTIVE-to-READ/WRITE wait, cycles.
- `CL`, 3: CAS latency; must match the programmed mode register.
- `T_DAL`, 5: write-recovery plus precharge wait, cycles.
- `T_REF`, 780: refresh interval, cycles (7.8 us).
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk_100m`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `sys_wr_req`  in  1  level write request; sampled only in W_IDLE.
- `sys_rd_req`  in  1  level read request; sampled only in W_IDLE.
- `sdwr_bytes`  in  [0:8]  write burst length in words; 0 encodes 512.
- `sdrd_bytes`  in  [0:8]  read burst length in words; 0 encodes 512.
- `init_state`  out  [0:3]  I_NOP=0, I_PRECHARGE=1, I_TRP=2, I_AUTO_REFRESH1=3, I_TRF1=4, I_AUTO_REFRESH2=5, I_TRF2=6, I_MRS=7, I_TMRD=8, I_DONE=9.
- `work_state`  out  [0:3]  W_IDLE=0, W_ACTIVE=1, W_TRCD=2, W_READ=3, W_CL=4, W_RD=5, W_WRITE=6, W_WD=7, W_TDAL=8, W_AR=9, W_TRFC=10.
- `cnt_clk`  out  [0:15]  cycles spent in the current state, starting at 0.
- `sys_r_wn`  out  1  1 = write transaction, 0 = read transaction; selects the address source.
- `sdram_busy`  out  1  high unless `init_state`==I_DONE and `work_state`==W_IDLE.
- `sdram_wr_ack`  out  1  system must present the next write word this cycle.
- `sdram_rd_ack`  out  1  the SDRAM drives a read word at the pins this cycle.
- `init_done`  out  1  high once `init_state` reaches I_DONE.

## Operation
- Reset values: `init_state`=I_NOP, `work_state`=W_IDLE, `cnt_clk`=0, `sys_r_wn`=1, `sdram_busy`=1, both acks 0, `init_done`=0, refresh counter 0, refresh pending 0.
- `cnt_clk` clears on every transition of either state register. Otherwise it increments and saturates at 16'hffff.
- **Init sequence:** I_NOP for T_POWERUP cycles, then I_PRECHARGE (1 cycle), I_TRP (T_RP cycles), I_AUTO_REFRESH1 (1), I_TRF1 (T_RFC), I_AUTO_REFRESH2 (1), I_TRF2 (T_RFC), I_MRS (1), I_TMRD (T_MRD), then I_DONE.
- I_DONE is terminal until reset.
- `work_state` is held at W_IDLE while `init_state`≠I_DONE.
- **Refresh counter:** starts on entry to I_DONE. It raises refresh-pending every T_REF cycles. Pending clears on entry to W_AR.
- **Arbitration in W_IDLE, fixed priority:** refresh pending > `sys_wr_req` > `sys_rd_req`.
- The losing request stays pending because requests are level.
- On selection, the burst length is latched and `sys_r_wn` is latched (1 for write, 0 for read). Both hold until the next selection.
- **Refresh path:** W_AR (1 cycle), then W_TRFC (T_RFC cycles), then W_IDLE.
- **Write path:** W_ACTIVE (1), W_TRCD (T_RCD), W_WRITE (1), W_WD (N−1 cycles, skipped when N=1), W_TDAL (T_DAL), then W_IDLE.
- **Read path:** W_ACTIVE (1), W_TRCD (T_RCD), W_READ (1), W_CL (CL), W_RD (N), W_TDAL (T_RP), then W_IDLE.
- A refresh becoming due mid-burst waits for W_IDLE. The worst case is a 512-word burst of about 530 cycles, which is less than T_REF.
- A reset mid-operation abandons the burst, restarts the full init sequence and clears pending refresh.

## Timing
- All outputs are registered. The command stage adds one register, so the pin command for state S appears one cycle after S.
- `sdram_wr_ack` is high exactly in W_WRITE and W_WD, for N consecutive cycles. This aligns with the registered data path driving DQ alongside the command.
- `sdram_rd_ack` is high exactly in W_RD, for N consecutive cycles. The first cycle falls at READ-on-pins + CL.
- A request seen high in W_IDLE at cycle t puts W_ACTIVE at t+1.
- With defaults, the first write word is acked at t+5.
- A new request is accepted on the first W_IDLE cycle after W_TDAL or W_TRFC. No extra idle cycle is inserted.

## Test plan
- **Init:** T_POWERUP=10, reset released → state codes 0 through 9 with dwell lengths 10, 1, 3, 1, 7, 1, 7, 1, 2. `init_done` and `sdram_busy`=0 at cycle 33.
- **Write burst:** `sys_wr_req` with `sdwr_bytes`=4 after init → W_ACTIVE, TRCD×3, WRITE, WD×3, TDAL×5. `sdram_wr_ack` high for exactly 4 cycles. `sys_r_wn`=1.
- **Read burst:** `sys_rd_req` with `sdrd_bytes`=4 → READ, CL×3. `sdram_rd_ack` high for 4 cycles, starting 4 cycles after W_READ. `sys_r_wn`=0.
- **Simultaneous requests:** `sys_wr_req` and `sys_rd_req` high in the same cycle → write is served first, then read immediately after returning to W_IDLE.
- **Refresh priority:** T_REF=50 with requests held continuously → W_AR taken at every interval boundary once idle. No more than 50 cycles plus one burst pass between refreshes.
- **Length and reset corners:** `sdwr_bytes`=0 → 512 acks. `rst` pulsed during W_WD → next cycle shows I_NOP, W_IDLE, acks 0 and `cnt_clk`=0.
